// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Moore-style main control FSM for the multicycle MIPS-subset CPU.
// Sequences the shared ALU, register file and unified memory across
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK. A per-state memory wait counter
// turns a stuck memory into a HALT with the sticky illegal flag set.
// Optional feature macro: PERF_CNT_EN (instruction and busy-cycle counters).

module multicycle_main_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        ext_zero,
    output logic        busy,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC_R = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        EXEC_I = 4'd11,
        IWB    = 4'd12,
        HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // Last wait count that is still tolerated; one more unready cycle is fatal.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t      state_q;
    state_t      next_state;
    state_t      after_term;
    logic [5:0]  op_q;
    logic [7:0]  wait_cnt;
    logic        mem_wait_state;
    logic        timeout;
    logic [2:0]  imm_alu_op;
    logic        imm_ext_zero;

    assign state          = state_q;
    assign busy           = (state_q != IDLE) && (state_q != HALT);
    assign mem_wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout        = mem_wait_state && !mem_ready && (wait_cnt == WAIT_LAST);
    assign after_term     = run ? FETCH : IDLE;

    // I-type ALU function and immediate extension, shared by EXEC_I and IWB.
    always_comb begin
        imm_alu_op   = 3'b000;
        imm_ext_zero = 1'b0;
        case (op_q)
            OP_SLTI: imm_alu_op = 3'b110;
            OP_ANDI: begin
                imm_alu_op   = 3'b100;
                imm_ext_zero = 1'b1;
            end
            OP_ORI: begin
                imm_alu_op   = 3'b101;
                imm_ext_zero = 1'b1;
            end
            default: imm_alu_op = 3'b000;
        endcase
    end

    // Next-state selection and per-state control strobes.
    always_comb begin
        next_state = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_source  = 2'b00;
        ext_zero   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) next_state = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)    next_state = DECODE;
                else if (timeout) next_state = HALT;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                          next_state = EXEC_R;
                    OP_LW, OP_SW:                      next_state = MEMADR;
                    OP_BEQ, OP_BNE:                    next_state = BRANCH;
                    OP_J:                              next_state = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = EXEC_I;
                    default:                           next_state = HALT;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)    next_state = MEMWB;
                else if (timeout) next_state = HALT;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = after_term;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = !timeout;
                if (mem_ready)    next_state = after_term;
                else if (timeout) next_state = HALT;
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b010;
                next_state = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = after_term;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                next_state = after_term;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                next_state = after_term;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = imm_alu_op;
                ext_zero   = imm_ext_zero;
                next_state = IWB;
            end
            IWB: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = imm_alu_op;
                ext_zero   = imm_ext_zero;
                reg_write  = 1'b1;
                next_state = after_term;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register, opcode latch, memory wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 6'd0;
            wait_cnt <= 8'd0;
            illegal  <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == DECODE) op_q <= opcode;
            if (mem_wait_state && (next_state == state_q)) wait_cnt <= wait_cnt + 8'd1;
            else                                           wait_cnt <= 8'd0;
            if ((next_state == HALT) && (state_q != HALT)) illegal <= 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic term_exit;

    assign term_exit = ((state_q == MEMWB) || (state_q == MEMWR) || (state_q == RWB) ||
                        (state_q == BRANCH) || (state_q == JUMP) || (state_q == IWB)) &&
                       ((next_state == FETCH) || (next_state == IDLE));

    // Free-running, wrapping counters of retired instructions and busy cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            if (term_exit) instr_count <= instr_count + 32'd1;
            if (busy)      cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign instr_count = 32'd0;
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Directed sequence through every instruction class, a memory stall, an
// illegal opcode, a fetch timeout and an asynchronous reset during a store.
// Expected control words are queued as each step is driven and popped when
// the DUT outputs are sampled on the falling edge.

module tb_multicycle_main_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_zero;
        logic       busy;
        logic       illegal;
    } ctrl_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  pc_source;
    logic        ext_zero;
    logic        busy;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    ctrl_t expQ[$];
    string tagQ[$];
    int    testCount;
    int    failCount;
    logic  expIllegal;
    ctrl_t e;

    multicycle_main_control #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .ext_zero(ext_zero), .busy(busy), .illegal(illegal), .state(state),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All-quiet control word for a state; busy follows the state, illegal the bench flag.
    function automatic ctrl_t base(input logic [3:0] st);
        ctrl_t c;
        c         = '0;
        c.state   = st;
        c.busy    = (st != 4'd0) && (st != 4'd13);
        c.illegal = expIllegal;
        return c;
    endfunction

    function automatic ctrl_t fetchWord(input logic ready);
        ctrl_t c;
        c           = base(4'd1);
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = ready;
        c.pc_write  = ready;
        return c;
    endfunction

    function automatic ctrl_t decodeWord();
        ctrl_t c;
        c           = base(4'd2);
        c.alu_src_b = 2'b11;
        return c;
    endfunction

    task automatic expectCtrl(input string tag, input ctrl_t exp);
        expQ.push_back(exp);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        ctrl_t obs;
        ctrl_t exp;
        string tag;
        obs = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, ext_zero, busy, illegal};
        testCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty: observed %h required a queued entry", obs);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            assert (obs === exp) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %h (state %0d) required %h (state %0d)",
                       tag, obs, obs.state, exp, exp.state);
            end
        end
    endtask

    // One clock of stimulus: queue the expectation, compare mid-cycle, advance.
    task automatic applyStimulus(input string tag, input ctrl_t exp);
        expectCtrl(tag, exp);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Fetch with ready memory and decode, leaving the bench in the execute state.
    task automatic fetchDecode(input logic [5:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        applyStimulus("fetch", fetchWord(1'b1));
        applyStimulus("decode", decodeWord());
    endtask

    initial begin
        testCount  = 0;
        failCount  = 0;
        expIllegal = 1'b0;
        rst_n      = 1'b0;
        run        = 1'b0;
        opcode     = 6'd0;
        zero       = 1'b0;
        mem_ready  = 1'b0;

        #3;
        expectCtrl("reset_state", base(4'd0));
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;
        applyStimulus("idle_run", base(4'd0));

        // R-type: 1,2,7,8 then back to FETCH
        fetchDecode(6'b000000);
        e = base(4'd7); e.alu_src_a = 1'b1; e.alu_op = 3'b010;
        applyStimulus("exec_r", e);
        e = base(4'd8); e.reg_write = 1'b1; e.reg_dst = 1'b1;
        applyStimulus("rwb", e);

        // LW with three stall cycles in MEMRD
        fetchDecode(6'b100011);
        e = base(4'd3); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        applyStimulus("lw_memadr", e);
        mem_ready = 1'b0;
        e = base(4'd4); e.mem_read = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("lw_memrd_wait", e);
        mem_ready = 1'b1;
        applyStimulus("lw_memrd_ready", e);
        e = base(4'd5); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        applyStimulus("lw_memwb", e);

        // BEQ taken, BNE not taken, both with zero = 1
        zero = 1'b1;
        fetchDecode(6'b000100);
        e = base(4'd9); e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01; e.pc_write = 1'b1;
        applyStimulus("beq_taken", e);
        fetchDecode(6'b000101);
        e.pc_write = 1'b0;
        applyStimulus("bne_not_taken", e);
        zero = 1'b0;

        // Jump
        fetchDecode(6'b000010);
        e = base(4'd10); e.pc_source = 2'b10; e.pc_write = 1'b1;
        applyStimulus("jump", e);

        // ANDI: zero-extended AND, held into IWB
        fetchDecode(6'b001100);
        e = base(4'd11); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100; e.ext_zero = 1'b1;
        applyStimulus("andi_exec", e);
        e.state = 4'd12; e.reg_write = 1'b1;
        applyStimulus("andi_iwb", e);

        // SLTI, dropping run during writeback so the FSM parks in IDLE
        fetchDecode(6'b001010);
        e = base(4'd11); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b110;
        applyStimulus("slti_exec", e);
        run = 1'b0;
        e.state = 4'd12; e.reg_write = 1'b1;
        applyStimulus("slti_iwb", e);
        applyStimulus("idle_after_run_low", base(4'd0));
        run = 1'b1;
        applyStimulus("idle_restart", base(4'd0));

        // SW stalled in MEMWR, then asynchronous reset mid-write
        fetchDecode(6'b101011);
        e = base(4'd3); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        applyStimulus("sw_memadr", e);
        mem_ready = 1'b0;
        e = base(4'd6); e.mem_write = 1'b1; e.iord = 1'b1;
        applyStimulus("sw_memwr_wait", e);
        #2;
        rst_n = 1'b0;
        #1;
        expectCtrl("reset_during_memwr", base(4'd0));
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("idle_after_reset", base(4'd0));

        // Illegal opcode: sticky HALT that ignores run
        fetchDecode(6'b111111);
        expIllegal = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("halt_illegal", base(4'd13));
        rst_n = 1'b0;
        expIllegal = 1'b0;
        #1;
        expectCtrl("reset_clears_illegal", base(4'd0));
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("idle_after_halt", base(4'd0));

        // Memory never ready during FETCH: 15 waiting cycles then HALT
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) applyStimulus("fetch_wait", fetchWord(1'b0));
        expIllegal = 1'b1;
        applyStimulus("fetch_timeout_halt", base(4'd13));
        applyStimulus("halt_holds", base(4'd13));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multicycle MIPS-subset CPU.
- Sequences the shared ALU, register file and unified memory across FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the 3-bit alu_op consumed by alu_control, using the same encoding: 000 add, 001 sub, 010 R-type, 100 and, 101 or, 110 slt.
- Supports R-type, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI and J.

Parameters:
MEM_WAIT_MAX, 15, maximum consecutive cycles spent waiting on mem_ready in any memory state before a bus error is declared (range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level enable; 1 = fetch and execute instructions
opcode  input  6  IR[31:26]; valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC load enable (already qualified for branches)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load enable
reg_dst  output  1  write register select: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
mem_to_reg  output  1  write data select: 1 = MDR, 0 = ALUOut
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A
alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign/zero-extended immediate, 11 = immediate shifted left by 2
alu_op  output  3  to alu_control
pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
ext_zero  output  1  zero-extend immediate (ANDI/ORI)
busy  output  1  state != IDLE and state != HALT
illegal  output  1  sticky error flag
state  output  4  current state, for debug

Behaviour:
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, RWB 8, BRANCH 9, JUMP 10, EXEC_I 11, IWB 12, HALT 13.
- Reset (rst_n = 0, asynchronous): state = IDLE; op_q = 0; wait_cnt = 0; illegal = 0.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Go to FETCH when run = 1.
- FETCH: mem_read = 1, alu_src_b = 01, alu_op = 000.
  - ir_write and pc_write = mem_ready; these are the only Mealy terms in this state.
  - mem_ready = 1 -> DECODE.
- DECODE: alu_src_b = 11, alu_op = 000. Latch op_q <= opcode. Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 / 101011 -> MEMADR
  - 000100 / 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000 / 001010 / 001100 / 001101 -> EXEC_I
  - any other opcode -> HALT, with illegal = 1
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. op_q = LW -> MEMRD, else -> MEMWR.
- MEMRD: mem_read = 1, iord = 1. Wait for mem_ready, then -> MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
- MEMWR: mem_write = 1, iord = 1. Wait for mem_ready.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 010 -> RWB.
- RWB: reg_write = 1, reg_dst = 1.
- BRANCH: alu_src_a = 1, alu_op = 001, pc_source = 01. pc_write = (op_q == BEQ & zero) | (op_q == BNE & ~zero).
- JUMP: pc_source = 10, pc_write = 1.
- EXEC_I: alu_src_a = 1, alu_src_b = 10. alu_op = 000 ADDI / 110 SLTI / 100 ANDI / 101 ORI. ext_zero = 1 for ANDI/ORI. -> IWB.
- IWB: reg_write = 1, reg_dst = 0. alu_op, alu_src_a, alu_src_b and ext_zero are held the same as in EXEC_I.
- Terminal states (MEMWB, MEMWR on ready, RWB, BRANCH, JUMP, IWB) -> FETCH if run = 1, else IDLE.
- run is only sampled at IDLE and at terminal states. An instruction already in flight always completes.
- Latency in cycles, with zero memory wait:
  - R-type / I-type: 4
  - LW: 5
  - SW: 4
  - branch / jump: 3
- Memory wait counter:
  - wait_cnt clears on entry to FETCH, MEMRD and MEMWR.
  - It increments each cycle mem_ready = 0 in those states.
  - Reaching MEM_WAIT_MAX with mem_ready still 0 -> HALT, illegal = 1. No write strobe is issued on that cycle.
- HALT: all outputs 0. Exits only via rst_n.
- Reset mid-instruction: all strobes drop immediately (asynchronous); the FSM restarts from IDLE.

Optional Feature:
- Macro: PERF_CNT_EN.
- Enabled: adds outputs instr_count[31:0] and cycle_count[31:0].
  - instr_count increments on every terminal-state exit.
  - cycle_count increments every cycle busy = 1.
  - Both reset to 0 and wrap at 2^32.
- Disabled: both ports still exist, tied to 0, with no counter flops.

Test Plan:
- Reset, run = 1, opcode 000000, mem_ready = 1 -> states 1,2,7,8,1. alu_op = 010 in EXEC_R. reg_write = 1 and reg_dst = 1 in RWB.
- LW (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles. MEMWB asserts reg_write = 1, mem_to_reg = 1.
- BEQ with zero = 1 -> pc_write = 1 in BRANCH. BNE with zero = 1 -> pc_write = 0 in BRANCH. alu_op = 001 in both.
- ANDI (001100) -> EXEC_I alu_op = 100, ext_zero = 1. SLTI -> alu_op = 110, ext_zero = 0.
- Opcode 111111 -> HALT, illegal = 1, busy = 0. Persists with run = 1 until rst_n pulses low.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX = 15 -> HALT after 15 cycles. Separately: rst_n low during MEMWR -> mem_write = 0 immediately, state = 0.
